// File: rtl/axi_common_pkg.sv
// Shared AXI response encoding used by the AXI-lite channel, the demux and its bench.
package axi_common;
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_lite_channel.sv
// AXI-lite channel bundle; clk/rstn travel with the bundle for blocks that want them.
interface axi_lite_channel
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  resp_t                   b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    output ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    input  ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational region decode: lowest-indexed matching region wins, a miss returns
// sel = NUM_SLAVES with hit = 0.
module axi_lite_addr_decode #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_WIDTH-1:0] MASK [NUM_SLAVES] = '{default: '0}
) (
  input  logic [ADDR_WIDTH-1:0]             addr,
  output logic [$clog2(NUM_SLAVES+1)-1:0]   sel,
  output logic                              hit
);
  localparam int SEL_W = $clog2(NUM_SLAVES + 1);

  always_comb begin
    sel = SEL_W'(NUM_SLAVES);
    hit = 1'b0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & MASK[i]) == BASE[i]) begin
        sel = SEL_W'(i);
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_lite_demux.sv
// AXI-lite 1:N address demux with one outstanding write and one outstanding read;
// unmapped accesses are answered locally with DECERR.
module axi_lite_demux
  import axi_common::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_WIDTH-1:0] MASK [NUM_SLAVES] = '{default: '0}
) (
  input  logic            clk,
  input  logic            rst,
  axi_lite_channel.slave  master,
  axi_lite_channel.master slaves [NUM_SLAVES]
);
  localparam int SEL_W = $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(NUM_SLAVES);

  if (ADDR_WIDTH != $bits(master.aw_addr)) begin : g_bad_addr_width
    $fatal(1, "axi_lite_demux: ADDR_WIDTH does not match the interface");
  end
  if (DATA_WIDTH != $bits(master.w_data)) begin : g_bad_data_width
    $fatal(1, "axi_lite_demux: DATA_WIDTH does not match the interface");
  end

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t              w_state_reg, w_state_next;
  r_state_t              r_state_reg, r_state_next;
  logic [ADDR_WIDTH-1:0] aw_addr_reg, ar_addr_reg;
  logic [2:0]            aw_prot_reg, ar_prot_reg;
  logic [SEL_W-1:0]      aw_sel_reg, ar_sel_reg;
  logic [SEL_W-1:0]      aw_dec_sel, ar_dec_sel;
  logic                  aw_dec_hit, ar_dec_hit;

  // Slot NUM_SLAVES of each gathered array is the built-in DECERR responder.
  logic                  s_aw_ready [NUM_SLAVES+1];
  logic                  s_w_ready  [NUM_SLAVES+1];
  logic                  s_b_valid  [NUM_SLAVES+1];
  resp_t                 s_b_resp   [NUM_SLAVES+1];
  logic                  s_ar_ready [NUM_SLAVES+1];
  logic                  s_r_valid  [NUM_SLAVES+1];
  logic [DATA_WIDTH-1:0] s_r_data   [NUM_SLAVES+1];
  resp_t                 s_r_resp   [NUM_SLAVES+1];

  axi_lite_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH), .BASE(BASE), .MASK(MASK)
  ) u_aw_decode (.addr(master.aw_addr), .sel(aw_dec_sel), .hit(aw_dec_hit));

  axi_lite_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH), .BASE(BASE), .MASK(MASK)
  ) u_ar_decode (.addr(master.ar_addr), .sel(ar_dec_sel), .hit(ar_dec_hit));

  assign s_aw_ready[NUM_SLAVES] = 1'b1;
  assign s_w_ready[NUM_SLAVES]  = 1'b1;
  assign s_b_valid[NUM_SLAVES]  = 1'b1;
  assign s_b_resp[NUM_SLAVES]   = RESP_DECERR;
  assign s_ar_ready[NUM_SLAVES] = 1'b1;
  assign s_r_valid[NUM_SLAVES]  = 1'b1;
  assign s_r_data[NUM_SLAVES]   = '0;
  assign s_r_resp[NUM_SLAVES]   = RESP_DECERR;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_port
    localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
    logic w_sel, r_sel;
    // Gating with rst drops downstream valids/readies in the cycle reset is sampled.
    assign w_sel = !rst && (aw_sel_reg == IDX);
    assign r_sel = !rst && (ar_sel_reg == IDX);

    assign slaves[gi].aw_valid = w_sel && (w_state_reg == W_ADDR);
    assign slaves[gi].aw_addr  = aw_addr_reg;
    assign slaves[gi].aw_prot  = aw_prot_reg;
    assign slaves[gi].w_valid  = w_sel && (w_state_reg == W_DATA) && master.w_valid;
    assign slaves[gi].w_data   = master.w_data;
    assign slaves[gi].w_strb   = master.w_strb;
    assign slaves[gi].b_ready  = w_sel && (w_state_reg == W_RESP) && master.b_ready;
    assign slaves[gi].ar_valid = r_sel && (r_state_reg == R_ADDR);
    assign slaves[gi].ar_addr  = ar_addr_reg;
    assign slaves[gi].ar_prot  = ar_prot_reg;
    assign slaves[gi].r_ready  = r_sel && (r_state_reg == R_DATA) && master.r_ready;

    assign s_aw_ready[gi] = slaves[gi].aw_ready;
    assign s_w_ready[gi]  = slaves[gi].w_ready;
    assign s_b_valid[gi]  = slaves[gi].b_valid;
    assign s_b_resp[gi]   = slaves[gi].b_resp;
    assign s_ar_ready[gi] = slaves[gi].ar_ready;
    assign s_r_valid[gi]  = slaves[gi].r_valid;
    assign s_r_data[gi]   = slaves[gi].r_data;
    assign s_r_resp[gi]   = slaves[gi].r_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      aw_addr_reg <= '0;
      aw_prot_reg <= '0;
      aw_sel_reg  <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (w_state_reg == W_IDLE && master.aw_valid) begin
        aw_addr_reg <= master.aw_addr;
        aw_prot_reg <= master.aw_prot;
        aw_sel_reg  <= aw_dec_sel;
      end
    end
  end

  always_comb begin
    w_state_next    = w_state_reg;
    master.aw_ready = 1'b0;
    master.w_ready  = 1'b0;
    master.b_valid  = 1'b0;
    master.b_resp   = RESP_OKAY;
    case (w_state_reg)
      W_IDLE: begin
        master.aw_ready = 1'b1;
        if (master.aw_valid) w_state_next = aw_dec_hit ? W_ADDR : W_DATA;
      end
      W_ADDR: if (s_aw_ready[aw_sel_reg]) w_state_next = W_DATA;
      W_DATA: begin
        master.w_ready = s_w_ready[aw_sel_reg];
        if (master.w_valid && s_w_ready[aw_sel_reg]) w_state_next = W_RESP;
      end
      W_RESP: begin
        master.b_valid = s_b_valid[aw_sel_reg];
        master.b_resp  = s_b_resp[aw_sel_reg];
        if (master.b_ready && s_b_valid[aw_sel_reg]) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      ar_addr_reg <= '0;
      ar_prot_reg <= '0;
      ar_sel_reg  <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (r_state_reg == R_IDLE && master.ar_valid) begin
        ar_addr_reg <= master.ar_addr;
        ar_prot_reg <= master.ar_prot;
        ar_sel_reg  <= ar_dec_sel;
      end
    end
  end

  always_comb begin
    r_state_next    = r_state_reg;
    master.ar_ready = 1'b0;
    master.r_valid  = 1'b0;
    master.r_data   = '0;
    master.r_resp   = RESP_OKAY;
    case (r_state_reg)
      R_IDLE: begin
        master.ar_ready = 1'b1;
        if (master.ar_valid) r_state_next = ar_dec_hit ? R_ADDR : R_DATA;
      end
      R_ADDR: if (s_ar_ready[ar_sel_reg]) r_state_next = R_DATA;
      R_DATA: begin
        master.r_valid = s_r_valid[ar_sel_reg];
        master.r_data  = s_r_data[ar_sel_reg];
        master.r_resp  = s_r_resp[ar_sel_reg];
        if (master.r_ready && s_r_valid[ar_sel_reg]) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_lite_demux.sv
// Directed bench for axi_lite_demux: routing, DECERR, overlap priority, backpressure,
// concurrent read/write and mid-transaction reset.
module tb_axi_lite_demux;
  import axi_common::*;

  logic clk;
  logic rst;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  int   b_hs     = 0;
  logic [63:0] rdata_cfg [2];

  assign rstn = ~rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) m_if (.clk(clk), .rstn(rstn));
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s_if [2] (.clk(clk), .rstn(rstn));

  // Slave 0 owns 0x0xxx; slave 1 owns 0x0000-0x1FFF and so overlaps slave 0.
  axi_lite_demux #(
    .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(64),
    .BASE('{32'h0000_0000, 32'h0000_0000}),
    .MASK('{32'h0000_F000, 32'h0000_E000})
  ) dut (
    .clk(clk), .rst(rst), .master(m_if), .slaves(s_if)
  );

  always @(negedge clk) if (m_if.b_valid && m_if.b_ready) b_hs++;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slv
    int          aw_vcyc = 0, aw_hs = 0, w_vcyc = 0, ar_vcyc = 0, ar_hs = 0, unstable = 0;
    logic [31:0] last_aw_addr = '0;
    logic [63:0] last_w_data  = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    always @(negedge clk) begin
      if (pend && (s_if[gi].aw_valid !== 1'b1 || s_if[gi].aw_addr !== pend_addr)) unstable++;
      pend      = s_if[gi].aw_valid && !s_if[gi].aw_ready;
      pend_addr = s_if[gi].aw_addr;
      if (s_if[gi].aw_valid) aw_vcyc++;
      if (s_if[gi].aw_valid && s_if[gi].aw_ready) begin aw_hs++; last_aw_addr = s_if[gi].aw_addr; end
      if (s_if[gi].w_valid) w_vcyc++;
      if (s_if[gi].w_valid && s_if[gi].w_ready) last_w_data = s_if[gi].w_data;
      if (s_if[gi].ar_valid) ar_vcyc++;
      if (s_if[gi].ar_valid && s_if[gi].ar_ready) ar_hs++;
    end

    // Leaf responder: one B after each W, one R after each AR.
    always @(posedge clk) begin
      if (rst) begin
        s_if[gi].b_valid <= 1'b0;
        s_if[gi].r_valid <= 1'b0;
        s_if[gi].b_resp  <= RESP_OKAY;
        s_if[gi].r_resp  <= RESP_OKAY;
        s_if[gi].r_data  <= '0;
      end else begin
        if (s_if[gi].w_valid && s_if[gi].w_ready) begin
          s_if[gi].b_valid <= 1'b1;
          s_if[gi].b_resp  <= RESP_OKAY;
        end else if (s_if[gi].b_valid && s_if[gi].b_ready) begin
          s_if[gi].b_valid <= 1'b0;
        end
        if (s_if[gi].ar_valid && s_if[gi].ar_ready) begin
          s_if[gi].r_valid <= 1'b1;
          s_if[gi].r_data  <= rdata_cfg[gi];
          s_if[gi].r_resp  <= RESP_OKAY;
        end else if (s_if[gi].r_valid && s_if[gi].r_ready) begin
          s_if[gi].r_valid <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input int bdly,
                          output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int cyc = 0, bwait = 0;
    resp = 2'bxx;
    @(posedge clk); #1;
    m_if.aw_valid = 1'b1; m_if.aw_addr = addr; m_if.aw_prot = 3'b000;
    m_if.w_valid  = 1'b1; m_if.w_data  = data; m_if.w_strb  = 8'hFF;
    m_if.b_ready  = (bdly == 0);
    while (!b_done && cyc < 100) begin
      @(negedge clk);
      if (m_if.aw_valid && m_if.aw_ready) aw_done = 1;
      if (m_if.w_valid && m_if.w_ready) w_done = 1;
      if (m_if.b_valid && m_if.b_ready) begin b_done = 1; resp = m_if.b_resp; end
      else if (m_if.b_valid) bwait++;
      @(posedge clk); #1;
      if (aw_done) m_if.aw_valid = 1'b0;
      if (w_done) m_if.w_valid = 1'b0;
      if (b_done) m_if.b_ready = 1'b0;
      else if (bwait >= bdly) m_if.b_ready = 1'b1;
      cyc++;
    end
    m_if.aw_valid = 1'b0; m_if.w_valid = 1'b0; m_if.b_ready = 1'b0;
    check("wr_complete", 64'(b_done), 64'd1);
    $display("txn write addr=%h data=%h resp=%0d cycles=%0d", addr, data, resp, cyc);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [63:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0;
    int cyc = 0;
    data = 'x; resp = 2'bxx;
    @(posedge clk); #1;
    m_if.ar_valid = 1'b1; m_if.ar_addr = addr; m_if.ar_prot = 3'b000; m_if.r_ready = 1'b1;
    while (!r_done && cyc < 100) begin
      @(negedge clk);
      if (m_if.ar_valid && m_if.ar_ready) ar_done = 1;
      if (m_if.r_valid && m_if.r_ready) begin r_done = 1; data = m_if.r_data; resp = m_if.r_resp; end
      @(posedge clk); #1;
      if (ar_done) m_if.ar_valid = 1'b0;
      if (r_done) m_if.r_ready = 1'b0;
      cyc++;
    end
    m_if.ar_valid = 1'b0; m_if.r_ready = 1'b0;
    check("rd_complete", 64'(r_done), 64'd1);
    $display("txn read addr=%h data=%h resp=%0d cycles=%0d", addr, data, resp, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    int s0_aw, s0_hs, s1_aw, s1_w, s0_ar, s1_ar_hs, all_v, b0, un0;

    rst = 1'b1;
    m_if.aw_valid = 0; m_if.aw_addr = '0; m_if.aw_prot = '0;
    m_if.w_valid = 0; m_if.w_data = '0; m_if.w_strb = '0; m_if.b_ready = 0;
    m_if.ar_valid = 0; m_if.ar_addr = '0; m_if.ar_prot = '0; m_if.r_ready = 0;
    for (int i = 0; i < 2; i++) rdata_cfg[i] = 64'h0;
    s_if[0].aw_ready = 1; s_if[0].w_ready = 1; s_if[0].ar_ready = 1;
    s_if[1].aw_ready = 1; s_if[1].w_ready = 1; s_if[1].ar_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_aw_ready", 64'(m_if.aw_ready), 64'd1);
    check("rst_ar_ready", 64'(m_if.ar_ready), 64'd1);
    check("rst_w_ready",  64'(m_if.w_ready),  64'd0);
    check("rst_b_valid",  64'(m_if.b_valid),  64'd0);
    check("rst_r_valid",  64'(m_if.r_valid),  64'd0);
    check("rst_slv_valids", 64'({s_if[0].aw_valid, s_if[0].w_valid, s_if[0].ar_valid,
                                 s_if[1].aw_valid, s_if[1].w_valid, s_if[1].ar_valid}), 64'd0);
    check("rst_slv_readies", 64'({s_if[0].b_ready, s_if[0].r_ready,
                                  s_if[1].b_ready, s_if[1].r_ready}), 64'd0);

    // Write to 0x0008: both regions match, slave 0 wins.
    s1_aw = g_slv[1].aw_vcyc; s1_w = g_slv[1].w_vcyc; s0_hs = g_slv[0].aw_hs;
    do_write(32'h0000_0008, 64'hDEAD, 0, bresp);
    check("wr0_resp", 64'(bresp), 64'(RESP_OKAY));
    check("wr0_s0_addr", 64'(g_slv[0].last_aw_addr), 64'h0008);
    check("wr0_s0_data", g_slv[0].last_w_data, 64'hDEAD);
    check("wr0_s0_aw_hs", 64'(g_slv[0].aw_hs - s0_hs), 64'd1);
    check("wr0_s1_quiet", 64'((g_slv[1].aw_vcyc - s1_aw) + (g_slv[1].w_vcyc - s1_w)), 64'd0);

    // Read of 0x1010 lands only in slave 1's region.
    rdata_cfg[0] = 64'hBAD0; rdata_cfg[1] = 64'h1234;
    s0_ar = g_slv[0].ar_vcyc; s1_ar_hs = g_slv[1].ar_hs;
    do_read(32'h0000_1010, rdata, rresp);
    check("rd1_data", rdata, 64'h1234);
    check("rd1_resp", 64'(rresp), 64'(RESP_OKAY));
    check("rd1_s0_ar_quiet", 64'(g_slv[0].ar_vcyc - s0_ar), 64'd0);
    check("rd1_s1_ar_hs", 64'(g_slv[1].ar_hs - s1_ar_hs), 64'd1);

    // Unmapped 0x5000 for both paths.
    all_v = g_slv[0].aw_vcyc + g_slv[0].w_vcyc + g_slv[0].ar_vcyc
          + g_slv[1].aw_vcyc + g_slv[1].w_vcyc + g_slv[1].ar_vcyc;
    do_write(32'h0000_5000, 64'h5555, 0, bresp);
    do_read(32'h0000_5000, rdata, rresp);
    check("err_b_resp", 64'(bresp), 64'(RESP_DECERR));
    check("err_r_resp", 64'(rresp), 64'(RESP_DECERR));
    check("err_r_data", rdata, 64'h0);
    check("err_no_slave_valid", 64'(g_slv[0].aw_vcyc + g_slv[0].w_vcyc + g_slv[0].ar_vcyc
          + g_slv[1].aw_vcyc + g_slv[1].w_vcyc + g_slv[1].ar_vcyc - all_v), 64'd0);

    // Overlapping address 0x0010 with slave 0 AW stall and master B backpressure.
    s0_aw = g_slv[0].aw_vcyc; s1_aw = g_slv[1].aw_vcyc; b0 = b_hs; un0 = g_slv[0].unstable;
    s_if[0].aw_ready = 1'b0;
    fork
      do_write(32'h0000_0010, 64'h0F0F, 3, bresp);
      begin
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("bp_s0_aw_valid", 64'(s_if[0].aw_valid), 64'd1);
        check("bp_s1_aw_valid", 64'(s_if[1].aw_valid), 64'd0);
        check("bp_w_held_off", 64'(m_if.w_ready), 64'd0);
        check("bp_aw_ready_low", 64'(m_if.aw_ready), 64'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        s_if[0].aw_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    check("bp_resp", 64'(bresp), 64'(RESP_OKAY));
    check("bp_s0_aw_cycles", 64'(g_slv[0].aw_vcyc - s0_aw), 64'd6);
    check("bp_s1_aw_quiet", 64'(g_slv[1].aw_vcyc - s1_aw), 64'd0);
    check("bp_aw_stable", 64'(g_slv[0].unstable - un0), 64'd0);
    check("bp_one_b", 64'(b_hs - b0), 64'd1);
    check("bp_s0_addr", 64'(g_slv[0].last_aw_addr), 64'h0010);

    // Concurrent write to slave 0 and read from slave 1.
    rdata_cfg[1] = 64'h5678;
    fork
      do_write(32'h0000_0020, 64'hBEEF, 0, bresp);
      do_read(32'h0000_1040, rdata, rresp);
    join
    check("cc_b_resp", 64'(bresp), 64'(RESP_OKAY));
    check("cc_s0_data", g_slv[0].last_w_data, 64'hBEEF);
    check("cc_r_data", rdata, 64'h5678);
    check("cc_r_resp", 64'(rresp), 64'(RESP_OKAY));

    // Park a write in W_DATA with slave 0 refusing W, then reset.
    s_if[0].w_ready = 1'b0;
    @(posedge clk); #1;
    m_if.aw_valid = 1'b1; m_if.aw_addr = 32'h0000_0040; m_if.w_valid = 1'b0; m_if.b_ready = 1'b0;
    @(posedge clk); #1;
    m_if.aw_valid = 1'b0;
    @(posedge clk); #1;
    m_if.w_valid = 1'b1; m_if.w_data = 64'h7777;
    @(negedge clk);
    check("rst_mid_w_valid", 64'(s_if[0].w_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_aw_ready", 64'(m_if.aw_ready), 64'd1);
    check("rst_mid_w_ready", 64'(m_if.w_ready), 64'd0);
    check("rst_mid_b_valid", 64'(m_if.b_valid), 64'd0);
    check("rst_mid_slv_valids", 64'({s_if[0].aw_valid, s_if[0].w_valid, s_if[0].ar_valid,
                                     s_if[1].aw_valid, s_if[1].w_valid, s_if[1].ar_valid}), 64'd0);
    m_if.w_valid = 1'b0;
    s_if[0].w_ready = 1'b1;

    do_write(32'h0000_0030, 64'hCAFE, 0, bresp);
    check("post_rst_resp", 64'(bresp), 64'(RESP_OKAY));
    check("post_rst_data", g_slv[0].last_w_data, 64'hCAFE);
    check("post_rst_addr", 64'(g_slv[0].last_aw_addr), 64'h0030);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
